// File: rtl/inv_cipher_aes.sv
// rtl/inv_cipher_aes.sv - AES-128 inverse cipher, one inverse round per clock
// Round keys are streamed in reverse order by an external source indexed by current_round.
module inv_cipher_aes (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [127:0] ciphertext,
  input  logic [127:0] round_ks,
  output logic         can_supply_last,
  output logic [3:0]   current_round,
  output logic [127:0] plaintext,
  output logic         is_busy
);

  logic [127:0] state_q, state_d;
  logic [127:0] pt_q, pt_d;
  logic [3:0]   round_q, round_d;
  logic         busy_q, busy_d;
  logic [127:0] sub_shift, key_added, mixed;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] t;
    t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Row r rotates right by r columns: out s[r][c] takes in s[r][c-r]
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    end
    return o;
  endfunction

  assign sub_shift = inv_sub_bytes(inv_shift_rows(state_q));
  assign key_added = sub_shift ^ round_ks;
  assign mixed     = inv_mix_columns(key_added);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      pt_q    <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pt_q    <= pt_d;
      round_q <= round_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pt_d    = pt_q;
    round_d = round_q;
    busy_d  = busy_q;
    if (!busy_q) begin
      if (en) begin
        state_d = ciphertext ^ round_ks;
        round_d = 4'd1;
        busy_d  = 1'b1;
      end
    end else if (round_q == 4'd10) begin
      pt_d    = key_added;
      round_d = 4'd0;
      busy_d  = 1'b0;
    end else begin
      state_d = mixed;
      round_d = round_q + 4'd1;
    end
  end

  always_comb begin
    can_supply_last = busy_q && (round_q == 4'd10);
    current_round   = round_q;
    plaintext       = pt_q;
    is_busy         = busy_q;
  end

endmodule

// File: tb/tb_inv_cipher_aes.sv
// tb/tb_inv_cipher_aes.sv - self-checking bench for inv_cipher_aes
// Reference: forward AES-128 with generated S-box and key schedule; DUT must invert it.
module tb_inv_cipher_aes;

  logic         clk;
  logic         rst;
  logic         en;
  logic [127:0] ciphertext;
  logic [127:0] round_ks;
  logic         can_supply_last;
  logic [3:0]   current_round;
  logic [127:0] plaintext;
  logic         is_busy;

  logic [7:0]   sbox [0:255];
  logic [127:0] rk [0:10];
  logic [127:0] last_pt;
  int           n_cmp;
  int           n_err;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  inv_cipher_aes dut (
    .clk(clk), .rst(rst), .en(en), .ciphertext(ciphertext), .round_ks(round_ks),
    .can_supply_last(can_supply_last), .current_round(current_round),
    .plaintext(plaintext), .is_busy(is_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key source: K(10 - current_round), combinational
  always_comb begin
    if (current_round <= 4'd10) round_ks = rk[4'd10 - current_round];
    else round_ks = '0;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic gen_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end
    sbox[0] = 8'h63;
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s [0:15];
    logic [7:0]   t [0:15];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] k;
    logic [127:0] o;
    k = rk[0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = sbox[s[4*((c+r)%4)+r]];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      k = rk[rnd];
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Called at a negedge with the core idle and keys loaded
  task automatic run_block(input string tag, input logic [127:0] ct,
                           input logic [127:0] exp_pt, input bit lock);
    check({tag, "_idle"}, {127'b0, is_busy}, 128'd0);
    ciphertext = ct;
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
    for (int step = 1; step <= 10; step++) begin
      check({tag, "_round"}, {124'b0, current_round}, step);
      check({tag, "_last"}, {127'b0, can_supply_last}, (step == 10) ? 128'd1 : 128'd0);
      check({tag, "_busy"}, {127'b0, is_busy}, 128'd1);
      en = lock && (step == 3 || step == 10);
      @(posedge clk);
      @(negedge clk);
    end
    en = 1'b0;
    check({tag, "_done_busy"}, {127'b0, is_busy}, 128'd0);
    check({tag, "_done_round"}, {124'b0, current_round}, 128'd0);
    check({tag, "_pt"}, plaintext, exp_pt);
    last_pt = exp_pt;
  endtask

  initial begin
    logic [127:0] key, pt, hold;
    bit           found;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    en = 1'b0;
    ciphertext = '0;
    gen_sbox();
    load_key(C1_KEY);
    repeat (2) @(negedge clk);
    check("rst_pt", plaintext, 128'd0);
    check("rst_round", {124'b0, current_round}, 128'd0);
    check("rst_busy", {127'b0, is_busy}, 128'd0);
    check("rst_last", {127'b0, can_supply_last}, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    load_key(C1_KEY);
    run_block("c1", C1_CT, C1_PT, 1'b0);
    load_key(B_KEY);
    run_block("fipsb", B_CT, B_PT, 1'b0);
    load_key(C1_KEY);
    run_block("lock", C1_CT, C1_PT, 1'b1);

    for (int n = 0; n < 8; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      run_block("rand", aes_enc(pt), pt, 1'b0);
    end

    // en held high: C.1 then B, restart every 11 cycles
    hold = last_pt;
    en = 1'b1;
    for (int c = 0; c < 22; c++) begin
      if (c == 11) hold = C1_PT;
      check("b2b_busy", {127'b0, is_busy}, (c == 0 || c == 11) ? 128'd0 : 128'd1);
      check("b2b_round", {124'b0, current_round}, c % 11);
      check("b2b_pt", plaintext, hold);
      if (c == 0) begin load_key(C1_KEY); ciphertext = C1_CT; end
      if (c == 11) begin load_key(B_KEY); ciphertext = B_CT; end
      @(posedge clk);
      @(negedge clk);
    end
    en = 1'b0;
    check("b2b_final_pt", plaintext, B_PT);
    check("b2b_final_busy", {127'b0, is_busy}, 128'd0);

    // Asynchronous reset mid-block
    load_key(C1_KEY);
    ciphertext = C1_CT;
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (current_round == 4'd5) found = 1'b1;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    check("mid_reached5", {127'b0, found}, 128'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_pt", plaintext, 128'd0);
    check("mid_rst_round", {124'b0, current_round}, 128'd0);
    check("mid_rst_busy", {127'b0, is_busy}, 128'd0);
    check("mid_rst_last", {127'b0, can_supply_last}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    last_pt = '0;
    run_block("after_rst", C1_CT, C1_PT, 1'b0);

    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      @(negedge clk);
      check("idle_pt", plaintext, last_pt);
      check("idle_round", {124'b0, current_round}, 128'd0);
      check("idle_busy", {127'b0, is_busy}, 128'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inv_cipher_aes.md
# inv_cipher_aes

Round-iterative AES-128 inverse cipher (decryption) core, one inverse round per clock, 128-bit datapath. It uses the same round-key-streaming handshake as the team's encryption core. An external key source drives `round_ks` each cycle from `current_round`, supplying round keys in reverse order (K10 first, K0 last). The block sits beside the encryption core and shares its key-supply and control conventions.

## Interface
- No parameters (AES-128 only; 10 rounds fixed).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  start request; sampled only while idle.
- `ciphertext`  in  128  input block; sampled on the start edge only.
- `round_ks`  in  128  round key for the current step, as indexed by `current_round`.
- `can_supply_last`  out  1  combinational; high when `current_round == 10`, i.e. K0 is required this cycle.
- `current_round`  out  4  registered step counter, 0..10.
- `plaintext`  out  128  registered result; holds the last completed block.
- `is_busy`  out  1  registered; high while a decryption is in progress.

## Operation
- Byte order: bits [127:120] hold byte 0 (first byte of the FIPS-197 hex string). State is column-major: s[r][c] = byte 4c+r. This applies to `ciphertext`, `round_ks` and `plaintext`.
- Registers: 128-bit `state`, 4-bit `current_round`, `is_busy`, 128-bit `plaintext`.
- IDLE (`is_busy = 0`, `current_round = 0`):
  - If `en = 1` on an edge: `state <= ciphertext ^ round_ks` (round_ks = K10), `current_round <= 1`, `is_busy <= 1`.
  - Otherwise everything holds.
- ROUND (`is_busy = 1`, `current_round = r`, r in 1..9):
  - Required key: `round_ks` = K(10−r).
  - On the edge: `state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_ks)`, `current_round <= r+1`.
- FINAL (`is_busy = 1`, `current_round = 10`):
  - `can_supply_last = 1`; required key: `round_ks` = K0.
  - On the edge: `plaintext <= InvSubBytes(InvShiftRows(state)) ^ round_ks`, `current_round <= 0`, `is_busy <= 0`.
- `en` is ignored whenever `is_busy = 1`, including the FINAL cycle. No queuing of requests.
- `ciphertext` is read only on the start edge; it may change freely afterwards.
- `plaintext` changes only at FINAL completion. Starting a new block does not clear it.
- InvSubBytes uses the inverse S-box: a 256-entry table, or GF(2^8) inversion after the inverse affine map. Both must be bit-exact with FIPS-197.
- InvMixColumns coefficients per column: {0e,0b,0d,09}, polynomial x^8+x^4+x^3+x+1.

## Timing
- Reset (asynchronous, any time, including mid-operation):
  - `state = 0`, `plaintext = 0`, `current_round = 0`, `is_busy = 0`, `can_supply_last = 0`.
  - Any in-flight block is discarded.
  - The first start is accepted on the first edge with `rst = 0` and `en = 1`.
- Start at edge E0 → `is_busy` high after E0 through E10. Rounds run on E1..E9, FINAL on E10.
- After E10: `plaintext` is valid and `is_busy = 0`. Latency is 10 cycles from start edge to result.
- `current_round` reads 1..10 during cycles E0→E1 … E9→E10. The key source must present K(10−current_round) combinationally in each of those cycles.
- `can_supply_last` is high exactly one cycle per block (the E9→E10 cycle).
- Back-to-back: the earliest next start is the edge after E10. Throughput is one block per 11 cycles.
- Holding `en = 1` continuously restarts the core every 11 cycles.

## Test plan
- FIPS-197 C.1:
  - Key stream from key 000102…0f; ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; K10 = 13111d7fe3944a17f307a78b4d2b30c5 at start.
  - Required: after E10, `plaintext` = 00112233445566778899aabbccddeeff and `is_busy` falls.
  - `can_supply_last` high only in the cycle where `current_round = 10`.
- FIPS-197 B:
  - Key 2b7e151628aed2a6abf7158809cf4f3c, K10 = d014f9a8c9ee2589e13f0cc8b6630ca6, ciphertext 3925841d02dc09fbdc118597196a0b32.
  - Required: `plaintext` = 3243f6a8885a308d313198a2e0370734.
- Busy lockout:
  - Pulse `en` with a different ciphertext at `current_round` = 3 and again at 10.
  - Required: C.1 result unaffected, `current_round` sequence 1..10 unchanged, no restart.
- Back-to-back:
  - `en` held high for 22 cycles alternating the C.1 and B vectors.
  - Required: both results correct, `is_busy` low for exactly one cycle between blocks.
  - `plaintext` holds the C.1 result until the second completion.
- Reset mid-operation:
  - Assert `rst` asynchronously (between edges) at `current_round` = 5.
  - Required: all outputs 0 immediately.
  - A subsequent C.1 start completes correctly in 10 cycles.
- Idle hold:
  - `en = 0` for 50 cycles after a completion.
  - Required: `plaintext` stable, `current_round = 0`, `is_busy = 0`.
